// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter feeding the 7-segment digit decoder.
// Optional leading-zero blank flags are built only when LEADING_ZERO_BLANK_EN is defined.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_WIDTH = 14,
  parameter int unsigned DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] max_decimal(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_decimal(DIGITS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     scratch_q, scratch_d;
  logic [BCD_W-1:0]     adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 overflow_q, overflow_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;

  // Add-3 correction on every nibble >= 5 before the shift.
  always_comb begin
    adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                    : scratch_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    bcd_d      = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d      = bin_in;
          scratch_d  = '0;
          cnt_d      = CNT_W'(BIN_WIDTH);
          ovf_pend_d = (64'(bin_in) > MAX_VAL);
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // Carries out of the top digit fall off; overflow was decided at load.
        scratch_d = {adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
        bin_d     = {bin_q[BIN_WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d      = ovf_pend_q ? {DIGITS{4'h9}} : scratch_q;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      bcd_q      <= bcd_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign bcd_out  = bcd_q;

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              lead_zero;

  // Blank a digit only while every digit above it is also zero; digit 0 always shows.
  always_comb begin
    blank_d   = blank_q;
    lead_zero = 1'b1;
    if (state_q == DONE) begin
      blank_d = '0;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
        lead_zero  = lead_zero & (scratch_q[4*i +: 4] == 4'd0);
        blank_d[i] = lead_zero & ~ovf_pend_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (default parameters).
// Expected blank flags follow LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin_in = '0;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] bcd_out;
  logic [3:0]  blank;

  int passed = 0;
  int total  = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit Lzb = 1'b1;
`else
  localparam bit Lzb = 1'b0;
`endif

  bin_to_bcd_seq #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bcd_out  (bcd_out),
    .blank    (blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Start a conversion of v, optionally pulsing start (value 7777) at edges N+p1 / N+p2,
  // then watch 40 cycles: first done latency, number of done pulses, busy and hold in SHIFT.
  task automatic convert(input logic [13:0] v, input int p1, input int p2,
                         output int lat, output int ndone, output bit busy_ok,
                         output bit hold_ok);
    logic [15:0] prev;
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    prev    = bcd_out;
    busy_ok = (busy === 1'b1);
    hold_ok = 1'b1;
    lat     = -1;
    ndone   = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == p1) || (k == p2);
      if (start) bin_in = 14'd7777;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (k < 15) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (bcd_out !== prev) hold_ok = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_conv(input string tag, input logic [13:0] v, input int p1, input int p2,
                         input logic [15:0] exp_bcd, input logic exp_ovf,
                         input logic [3:0] exp_blank_lzb);
    int lat, ndone;
    bit busy_ok, hold_ok;
    convert(v, p1, p2, lat, ndone, busy_ok, hold_ok);
    chk({tag, " latency"}, 64'(lat), 64'd15);
    chk({tag, " done count"}, 64'(ndone), 64'd1);
    chk({tag, " busy in shift"}, 64'(busy_ok), 64'd1);
    chk({tag, " hold in shift"}, 64'(hold_ok), 64'd1);
    chk({tag, " bcd_out"}, 64'(bcd_out), 64'(exp_bcd));
    chk({tag, " overflow"}, 64'(overflow), 64'(exp_ovf));
    chk({tag, " blank"}, 64'(blank), Lzb ? 64'(exp_blank_lzb) : 64'd0);
  endtask

  initial begin
    int ndone;

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    chk("reset bcd_out", 64'(bcd_out), 64'd0);
    chk("reset blank", 64'(blank), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_conv("zero", 14'd0, 0, 0, 16'h0000, 1'b0, 4'b1110);
    do_conv("1234", 14'd1234, 0, 0, 16'h1234, 1'b0, 4'b0000);
    do_conv("9999", 14'd9999, 0, 0, 16'h9999, 1'b0, 4'b0000);
    do_conv("10000", 14'd10000, 0, 0, 16'h9999, 1'b1, 4'b0000);
    do_conv("16383", 14'd16383, 0, 0, 16'h9999, 1'b1, 4'b0000);
    // Starts at edge N+5 (SHIFT) and N+15 (DONE) must both be dropped.
    do_conv("42 busy starts", 14'd42, 5, 15, 16'h0042, 1'b0, 4'b1100);
    do_conv("7777", 14'd7777, 0, 0, 16'h7777, 1'b0, 4'b0000);
    do_conv("305", 14'd305, 0, 0, 16'h0305, 1'b0, 4'b1000);
    do_conv("8000", 14'd8000, 0, 0, 16'h8000, 1'b0, 4'b0000);

    // Reset in the middle of a conversion.
    @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd5678;
    @(posedge clk);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort overflow", 64'(overflow), 64'd0);
    chk("abort bcd_out", 64'(bcd_out), 64'd0);
    chk("abort blank", 64'(blank), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);
    do_conv("5678", 14'd5678, 0, 0, 16'h5678, 1'b0, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
